// File: rtl/cpu_types_pkg.sv
// Shared CPU/bus types and width constants.
//   word_t     : 32-bit bus word
//   MEM_LAT_W  : width of the memory access-latency counter (latency 0..15)
package cpu_types_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BYTE_OFF_W = 2;
  localparam int unsigned MEM_LAT_W  = 4;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/bus_mem_if.sv
// Bus-to-memory interface between the coherence bus controller and memory.
//   dREN/dWEN    : read/write request, held until completion
//   daddr/dstore : byte address and write data
//   dwait        : high while a request is outstanding, low for the completion cycle
//   dload        : read data, valid only while dwait is low
// Modports: mem (memory responder side), ctrl (bus controller side).
interface bus_mem_if;
  import cpu_types_pkg::*;

  logic  dREN;
  logic  dWEN;
  logic  dwait;
  word_t daddr;
  word_t dstore;
  word_t dload;

  modport mem (
    input  dREN, dWEN, daddr, dstore,
    output dwait, dload
  );

  modport ctrl (
    output dREN, dWEN, daddr, dstore,
    input  dwait, dload
  );

endinterface

// File: rtl/bus_mem_array.sv
// Word storage for bus_mem_ram: synchronous write, asynchronous read,
// asynchronous clear of every word on reset.
//   CLK, nRST    : clock, async active-low reset (clears all words)
//   wen          : write enable, commits wdata to mem[widx] on the rising edge
//   widx, wdata  : write word index and data
//   ridx, rdata  : combinational read port
module bus_mem_array
  import cpu_types_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             wen,
  input  logic [IDX_W-1:0] widx,
  input  word_t            wdata,
  input  logic [IDX_W-1:0] ridx,
  output word_t            rdata
);

  word_t mem [DEPTH];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wen) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/bus_mem_ram.sv
// Memory-side responder for the bus-to-memory interface. Accepts single-word
// read/write requests, holds dwait high for LAT extra cycles, then completes
// in one cycle: read data on dload, or write committed to the word array.
//   CLK   : clock, rising edge
//   nRST  : async active-low reset
//   bmif  : bus_mem_if.mem (dREN, dWEN, daddr, dstore in; dwait, dload out)
// Parameters: LAT (0..15) extra wait cycles; DEPTH words, power of two (>= 2).
module bus_mem_ram
  import cpu_types_pkg::*;
#(
  parameter int unsigned LAT   = 2,
  parameter int unsigned DEPTH = 256
) (
  input logic      CLK,
  input logic      nRST,
  bus_mem_if.mem   bmif
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [MEM_LAT_W-1:0] LAT_CNT = MEM_LAT_W'(LAT);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_t;

  state_t                 state_q, state_d;
  logic [MEM_LAT_W-1:0]   cnt_q, cnt_d;
  logic                   wr_q;
  logic [IDX_W-1:0]       idx_q;
  word_t                  data_q;
  logic                   latch_en;
  logic                   mem_we;
  word_t                  rdata;

  logic                   req;
  logic                   req_wr;
  logic [IDX_W-1:0]       req_idx;
  logic                   req_match;

  // Byte offset and bits above the index alias and are deliberately dropped.
  logic unused_addr;
  assign unused_addr = ^{bmif.daddr[WORD_W-1:BYTE_OFF_W+IDX_W], bmif.daddr[BYTE_OFF_W-1:0]};

  assign req     = bmif.dREN | bmif.dWEN;
  assign req_wr  = bmif.dWEN;  // write wins when both are asserted
  assign req_idx = bmif.daddr[BYTE_OFF_W +: IDX_W];

  // Any change to the live request while waiting aborts the access.
  assign req_match = req && (req_wr == wr_q) && (req_idx == idx_q) && (bmif.dstore == data_q);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_en) begin
        wr_q   <= req_wr;
        idx_q  <= req_idx;
        data_q <= bmif.dstore;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    latch_en   = 1'b0;
    mem_we     = 1'b0;
    bmif.dwait = 1'b1;
    bmif.dload = '0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          latch_en = 1'b1;
          cnt_d    = LAT_CNT;
          state_d  = StAccess;
        end
      end
      StAccess: begin
        if (!req_match) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - MEM_LAT_W'(1);
        end
      end
      StDone: begin
        bmif.dwait = 1'b0;
        if (wr_q) begin
          mem_we = 1'b1;
        end else begin
          bmif.dload = rdata;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  bus_mem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .CLK   (CLK),
    .nRST  (nRST),
    .wen   (mem_we),
    .widx  (idx_q),
    .wdata (data_q),
    .ridx  (idx_q),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_bus_mem_ram.sv
// Self-checking bench for bus_mem_ram: three instances (LAT 0, 2, 15) driven
// by directed and random requests and checked against a word-array model.
module tb_bus_mem_ram;
  import cpu_types_pkg::*;

  localparam int unsigned NINST = 3;
  localparam int unsigned DEPTH = 256;

  function automatic int lat_of(input int i);
    return (i == 0) ? 0 : (i == 1) ? 2 : 15;
  endfunction

  logic  CLK;
  logic  nRST;
  logic  ren     [NINST];
  logic  wen     [NINST];
  word_t addr_v  [NINST];
  word_t store_v [NINST];
  logic  dwait_v [NINST];
  word_t dload_v [NINST];

  word_t model [NINST][DEPTH];

  int n_checks = 0;
  int n_fail   = 0;

  for (genvar g = 0; g < NINST; g++) begin : g_dut
    localparam int unsigned LatG = lat_of(g);
    bus_mem_if bif ();
    assign bif.dREN   = ren[g];
    assign bif.dWEN   = wen[g];
    assign bif.daddr  = addr_v[g];
    assign bif.dstore = store_v[g];
    assign dwait_v[g] = bif.dwait;
    assign dload_v[g] = bif.dload;

    bus_mem_ram #(
      .LAT   (LatG),
      .DEPTH (DEPTH)
    ) u_dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bmif (bif)
    );
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input word_t got, input word_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int idx_of(input word_t a);
    return int'((a >> 2) % DEPTH);
  endfunction

  task automatic clear_models();
    for (int i = 0; i < NINST; i++)
      for (int j = 0; j < DEPTH; j++) model[i][j] = '0;
  endtask

  // Called just after a negedge. Holds the request until completion, checks
  // latency (edges from first sighting to completion edge), read data, and
  // that dwait goes high again right after.
  task automatic do_access(input int i, input logic r, input logic w,
                           input word_t a, input word_t d);
    int    n;
    bit    done;
    word_t exp_rd;
    exp_rd     = model[i][idx_of(a)];
    ren[i]     = r;
    wen[i]     = w;
    addr_v[i]  = a;
    store_v[i] = d;
    n = 0;
    done = 0;
    while (!done && n < 40) begin
      @(posedge CLK);
      n++;
      @(negedge CLK);
      if (!dwait_v[i]) done = 1;
      else check_val($sformatf("dload_zero_wait[%0d]", i), dload_v[i], '0);
    end
    check_val($sformatf("latency[%0d] a=%h", i, a), word_t'(n), word_t'(lat_of(i) + 2));
    if (done && r && !w) check_val($sformatf("rdata[%0d] a=%h", i, a), dload_v[i], exp_rd);
    if (done && w) model[i][idx_of(a)] = d;
    @(posedge CLK);
    @(negedge CLK);
    check_val($sformatf("dwait_once[%0d]", i), word_t'(dwait_v[i]), 32'd1);
    ren[i] = 1'b0;
    wen[i] = 1'b0;
  endtask

  // Start a write at a, change address to a+4 after k edges (still waiting),
  // expect abort edge + fresh full access for the new address.
  task automatic do_abort(input int i, input word_t a, input word_t d, input int k);
    int n;
    bit done;
    ren[i]     = 1'b0;
    wen[i]     = 1'b1;
    addr_v[i]  = a;
    store_v[i] = d;
    for (int j = 0; j < k; j++) begin
      @(posedge CLK);
      @(negedge CLK);
      check_val($sformatf("abort_pre_dwait[%0d]", i), word_t'(dwait_v[i]), 32'd1);
    end
    addr_v[i] = a + 32'd4;
    n = 0;
    done = 0;
    while (!done && n < 40) begin
      @(posedge CLK);
      n++;
      @(negedge CLK);
      if (!dwait_v[i]) done = 1;
    end
    check_val($sformatf("abort_latency[%0d]", i), word_t'(n), word_t'(lat_of(i) + 3));
    if (done) model[i][idx_of(a + 32'd4)] = d;
    @(posedge CLK);
    @(negedge CLK);
    wen[i] = 1'b0;
  endtask

  initial begin
    int    n;
    int    sel;
    word_t a;
    word_t d;
    nRST = 1'b0;
    for (int i = 0; i < NINST; i++) begin
      ren[i] = 1'b0;
      wen[i] = 1'b0;
      addr_v[i] = '0;
      store_v[i] = '0;
    end
    clear_models();
    repeat (3) @(negedge CLK);
    for (int i = 0; i < NINST; i++) begin
      check_val($sformatf("rst_dwait[%0d]", i), word_t'(dwait_v[i]), 32'd1);
      check_val($sformatf("rst_dload[%0d]", i), dload_v[i], '0);
    end
    nRST = 1'b1;
    @(negedge CLK);

    // Directed on the LAT=2 instance.
    do_access(1, 1'b1, 1'b0, 32'h10, '0);
    do_access(1, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF);
    do_access(1, 1'b1, 1'b0, 32'h40, '0);
    check_val("model_40", model[1][idx_of(32'h40)], 32'hDEADBEEF);
    do_access(1, 1'b0, 1'b1, 32'h404, 32'h1234);
    do_access(1, 1'b1, 1'b0, 32'h004, '0);
    do_access(1, 1'b1, 1'b0, 32'h007, '0);
    do_access(1, 1'b1, 1'b1, 32'h80, 32'hA5A5A5A5);
    do_access(1, 1'b1, 1'b0, 32'h80, '0);
    do_abort(1, 32'h20, 32'h5555AAAA, 2);
    do_access(1, 1'b1, 1'b0, 32'h20, '0);
    do_access(1, 1'b1, 1'b0, 32'h24, '0);

    // Latency extremes.
    do_abort(0, 32'h30, 32'h0BADF00D, 1);
    for (int i = 0; i < NINST; i += 2) begin
      do_access(i, 1'b0, 1'b1, 32'h100, 32'h600D0000 + i);
      do_access(i, 1'b1, 1'b0, 32'h100, '0);
    end

    // Random traffic.
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < NINST; i++) begin
        a = ($urandom() & 32'hFFFF_F000) | (word_t'($urandom_range(0, 15)) << 2)
            | word_t'($urandom_range(0, 3));
        d = $urandom();
        sel = $urandom_range(0, 9);
        if (sel < 5) do_access(i, 1'b1, 1'b0, a, '0);
        else if (sel < 8) do_access(i, 1'b0, 1'b1, a, d);
        else if (sel < 9) do_access(i, 1'b1, 1'b1, a, d);
        else do_abort(i, a, d, $urandom_range(1, lat_of(i) + 1));
      end
    end

    // Async reset during a read completion cycle.
    do_access(1, 1'b0, 1'b1, 32'h10, 32'hCAFEF00D);
    ren[1] = 1'b1;
    addr_v[1] = 32'h10;
    store_v[1] = '0;
    n = 0;
    while (dwait_v[1] && n < 40) begin
      @(posedge CLK);
      n++;
      @(negedge CLK);
    end
    check_val("rst_pre_dload", dload_v[1], 32'hCAFEF00D);
    #2 nRST = 1'b0;
    #1;
    check_val("rst_async_dwait", word_t'(dwait_v[1]), 32'd1);
    check_val("rst_async_dload", dload_v[1], '0);
    @(posedge CLK);
    @(negedge CLK);
    ren[1] = 1'b0;
    nRST = 1'b1;
    clear_models();
    @(negedge CLK);
    do_access(1, 1'b1, 1'b0, 32'h10, '0);
    do_access(2, 1'b1, 1'b0, 32'h100, '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
